usb_cmd_dispatch: RTL and testbench
===================================

// Module: usb_cmd_dispatch
// PURPOSE
//  Sequences host commands received by the USB slave-FIFO interface to N on-board targets
//  (pulser, gain, ADC capture, ...). Sits between the USB block's cmd outputs and the targets.
//  Issues each command over a req/ack/done handshake, supervises it with a timeout and returns
//  a finish pulse + 16-bit finish code to the USB block for the host response.
// PARAMETERS
//  N_TGT      4        number of targets (1..16)
//  TO_W       20       width of timeout counter
//  TO_LIMIT   20'hFFFFF cycles allowed from issue to done before timeout
//  FIN_HOLD   4        cycles o_cmd_finish held high, then held low (>=3 for 2-flop sync)
// PORTS
//  i_clk_usb          in   1          USB interface clock
//  i_rst_n            in   1          reset, asynchronous, active-low
//  i_cmd_come         in   1          level from USB block; rising edge = new command valid
//  i_cmd              in   16         [15:8] target index, [7:0] opcode
//  i_cmd_param        in   32         command parameter
//  o_cmd_finish       out  1          rising edge signals command complete
//  o_cmd_finish_code  out  16         stable from finish rise until next command accepted
//  o_tgt_req          out  N_TGT      one-hot request, high until ack
//  o_tgt_op           out  8          opcode to target, stable req..done
//  o_tgt_param        out  32         parameter to target, stable req..done
//  i_tgt_ack          in   N_TGT      target accepted request
//  i_tgt_done         in   N_TGT      single-cycle completion pulse
//  i_tgt_status       in   8*N_TGT    target status, sampled on done
//  o_busy             out  1          high outside IDLE
//  o_err_overrun      out  1          sticky: command edge seen while not IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, code 16'h0000.
//  Edge detect: i_cmd_come registered; rise in IDLE latches cmd/param (1-cycle latency to req).
//  IDLE  -> ISSUE on rise if i_cmd[15:8] < N_TGT; else code 16'h8001, -> FINISH.
//  ISSUE: req[idx]=1; timer runs; ack[idx] -> EXEC, req drops next cycle.
//         ack and done same cycle -> capture status, -> FINISH (skip EXEC).
//  EXEC : wait done[idx]; code {8'h00, status[idx]}, -> FINISH. done before ack ignored.
//  Timeout: timer == TO_LIMIT in ISSUE/EXEC -> req dropped, code 16'h8002, -> FINISH.
//  FINISH: o_cmd_finish=1 for FIN_HOLD cycles -> GAP. GAP: finish=0 FIN_HOLD cycles -> IDLE.
//  Timer cleared on IDLE exit; saturates, never wraps. Other targets' ack/done ignored.
//  Command rise in any non-IDLE state: dropped, o_err_overrun set (cleared only by reset).
//  Reset mid-command: req dropped immediately (async), no finish generated.
// CONFIGURATION
//  USB_CMD_BCAST_EN defined: target index 8'hFF asserts all req bits; each drops on own ack;
//    completes when every target has signalled done; code {8'h00, OR of statuses};
//    timeout applies to the set as a whole.
//  Not defined: 8'hFF treated as any invalid index -> code 16'h8001.
// STRUCTURE
//  Package usb_cmd_pkg: state encodings (one-hot), codes CODE_OK_HI=8'h00, CODE_BAD_TGT=16'h8001,
//  CODE_TIMEOUT=16'h8002, field positions of target index/opcode.
//  One sub-module: usb_cmd_timer (clear/enable/limit, saturating, expire flag).
// TESTING
//  cmd 16'h0203 param 32'h1234, tgt2 ack@+3 done@+10 status 8'h5A
//    -> req[2] 3 cycles, op 8'h03, finish rise, code 16'h005A.
//  cmd 16'h0901 with N_TGT=4 -> no req, finish rise within 2 cycles, code 16'h8001.
//  cmd to tgt1, no ack (TO_LIMIT=100) -> req drops at 100, code 16'h8002.
//  tgt0 ack and done same cycle, status 8'h01 -> code 16'h0001, finish high exactly FIN_HOLD.
//  second cmd_come rise during EXEC -> ignored, o_err_overrun=1, first completes normally.
//  USB_CMD_BCAST_EN, cmd 16'hFF07, statuses 01/02/04/08 staggered -> code 16'h000F after last done.

Source files
------------

// File: rtl/usb_cmd_pkg.sv
// Shared encodings for the USB command dispatcher: FSM states, finish codes and
// the field layout of the 16-bit host command word.
package usb_cmd_pkg;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_ISSUE  = 5'b00010,
        ST_EXEC   = 5'b00100,
        ST_FINISH = 5'b01000,
        ST_GAP    = 5'b10000
    } state_e;

    localparam logic [7:0]  CODE_OK_HI   = 8'h00;
    localparam logic [15:0] CODE_BAD_TGT = 16'h8001;
    localparam logic [15:0] CODE_TIMEOUT = 16'h8002;

    localparam int CMD_IDX_MSB = 15;
    localparam int CMD_IDX_LSB = 8;
    localparam int CMD_OP_MSB  = 7;
    localparam int CMD_OP_LSB  = 0;

    localparam logic [7:0] BCAST_IDX = 8'hFF;

endpackage

// File: rtl/usb_cmd_timer.sv
// Saturating cycle counter that supervises an outstanding command; o_expire is
// high while the count sits at i_limit.
module usb_cmd_timer #(
    parameter int W = 20
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_enable,
    input  logic [W-1:0] i_limit,
    output logic         o_expire
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && (count_q != i_limit)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expire = (count_q == i_limit);

endmodule

// File: rtl/usb_cmd_dispatch.sv
// Issues host commands to on-board targets over req/ack/done and reports a finish code.
// Define USB_CMD_BCAST_EN to let target index 8'hFF address every target at once.
module usb_cmd_dispatch
    import usb_cmd_pkg::*;
#(
    parameter int          N_TGT    = 4,
    parameter int          TO_W     = 20,
    parameter int unsigned TO_LIMIT = 20'hFFFFF,
    parameter int          FIN_HOLD = 4
) (
    input  logic                 i_clk_usb,
    input  logic                 i_rst_n,
    input  logic                 i_cmd_come,
    input  logic [15:0]          i_cmd,
    input  logic [31:0]          i_cmd_param,
    output logic                 o_cmd_finish,
    output logic [15:0]          o_cmd_finish_code,
    output logic [N_TGT-1:0]     o_tgt_req,
    output logic [7:0]           o_tgt_op,
    output logic [31:0]          o_tgt_param,
    input  logic [N_TGT-1:0]     i_tgt_ack,
    input  logic [N_TGT-1:0]     i_tgt_done,
    input  logic [8*N_TGT-1:0]   i_tgt_status,
    output logic                 o_busy,
    output logic                 o_err_overrun
);

    localparam int HOLD_W = (FIN_HOLD > 1) ? $clog2(FIN_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FIN_HOLD - 1);

    state_e              state_q, state_d;
    logic                cmd_come_q, cmd_come_d;
    logic [N_TGT-1:0]    req_q, req_d;
    logic [N_TGT-1:0]    pend_q, pend_d;
    logic [7:0]          stat_q, stat_d;
    logic [7:0]          op_q, op_d;
    logic [31:0]         param_q, param_d;
    logic [15:0]         code_q, code_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                overrun_q, overrun_d;

    logic                cmd_rise;
    logic [7:0]          cmd_idx;
    logic [N_TGT-1:0]    sel_mask;
    logic [N_TGT-1:0]    done_ok;
    logic [7:0]          stat_or;
    logic                timer_expire;

    assign cmd_rise = i_cmd_come & ~cmd_come_q;
    assign cmd_idx  = i_cmd[CMD_IDX_MSB:CMD_IDX_LSB];

    // An index with no matching target yields an empty mask and is rejected.
    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < N_TGT; i++) begin
            sel_mask[i] = (cmd_idx == 8'(i));
        end
`ifdef USB_CMD_BCAST_EN
        if (cmd_idx == BCAST_IDX) begin
            sel_mask = '1;
        end
`endif
    end

    // A done only counts from a target that still owes one and has acked.
    always_comb begin
        done_ok = i_tgt_done & pend_q & (~req_q | i_tgt_ack);
        stat_or = '0;
        for (int i = 0; i < N_TGT; i++) begin
            if (done_ok[i]) begin
                stat_or = stat_or | i_tgt_status[8*i +: 8];
            end
        end
    end

    usb_cmd_timer #(
        .W(TO_W)
    ) u_timer (
        .i_clk    (i_clk_usb),
        .i_rst_n  (i_rst_n),
        .i_clear  (state_q == ST_IDLE),
        .i_enable ((state_q == ST_ISSUE) || (state_q == ST_EXEC)),
        .i_limit  (TO_W'(TO_LIMIT)),
        .o_expire (timer_expire)
    );

    always_comb begin
        state_d    = state_q;
        cmd_come_d = i_cmd_come;
        req_d      = req_q;
        pend_d     = pend_q;
        stat_d     = stat_q;
        op_d       = op_q;
        param_d    = param_q;
        code_d     = code_q;
        hold_d     = hold_q;
        overrun_d  = overrun_q | (cmd_rise & (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (cmd_rise) begin
                    hold_d = '0;
                    if (sel_mask != '0) begin
                        req_d   = sel_mask;
                        pend_d  = sel_mask;
                        stat_d  = '0;
                        op_d    = i_cmd[CMD_OP_MSB:CMD_OP_LSB];
                        param_d = i_cmd_param;
                        state_d = ST_ISSUE;
                    end else begin
                        code_d  = CODE_BAD_TGT;
                        state_d = ST_FINISH;
                    end
                end
            end
            // ISSUE and EXEC share one rule set; EXEC just means every req is acked.
            ST_ISSUE, ST_EXEC: begin
                req_d  = req_q & ~i_tgt_ack;
                pend_d = pend_q & ~done_ok;
                stat_d = stat_q | stat_or;
                if (pend_d == '0) begin
                    code_d  = {CODE_OK_HI, stat_d};
                    state_d = ST_FINISH;
                end else if (timer_expire) begin
                    req_d   = '0;
                    code_d  = CODE_TIMEOUT;
                    state_d = ST_FINISH;
                end else if (req_d == '0) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_FINISH: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = ST_GAP;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                req_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk_usb or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            cmd_come_q <= 1'b0;
            req_q      <= '0;
            pend_q     <= '0;
            stat_q     <= '0;
            op_q       <= '0;
            param_q    <= '0;
            code_q     <= '0;
            hold_q     <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_come_q <= cmd_come_d;
            req_q      <= req_d;
            pend_q     <= pend_d;
            stat_q     <= stat_d;
            op_q       <= op_d;
            param_q    <= param_d;
            code_q     <= code_d;
            hold_q     <= hold_d;
            overrun_q  <= overrun_d;
        end
    end

    assign o_cmd_finish      = (state_q == ST_FINISH);
    assign o_cmd_finish_code = code_q;
    assign o_tgt_req         = req_q;
    assign o_tgt_op          = op_q;
    assign o_tgt_param       = param_q;
    assign o_busy            = (state_q != ST_IDLE);
    assign o_err_overrun     = overrun_q;

endmodule

// File: tb/tb_usb_cmd_dispatch.sv
// Self-checking bench for usb_cmd_dispatch: directed and randomized commands with
// target handshakes, compared against a per-command reference model.
module tb_usb_cmd_dispatch;

    localparam int N_TGT    = 4;
    localparam int TO_W     = 20;
    localparam int TO_LIMIT = 100;
    localparam int FIN_HOLD = 4;
    localparam int BUDGET   = 400;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cmd_come = 1'b0;
    logic [15:0]          cmd = '0;
    logic [31:0]          cmd_param = '0;
    logic [N_TGT-1:0]     tgt_ack = '0;
    logic [N_TGT-1:0]     tgt_done = '0;
    logic [8*N_TGT-1:0]   tgt_status = '0;
    logic                 cmd_finish;
    logic [15:0]          finish_code;
    logic [N_TGT-1:0]     tgt_req;
    logic [7:0]           tgt_op;
    logic [31:0]          tgt_param;
    logic                 busy;
    logic                 err_overrun;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_overrun = 1'b0;

    always #5 clk = ~clk;

    usb_cmd_dispatch #(
        .N_TGT    (N_TGT),
        .TO_W     (TO_W),
        .TO_LIMIT (TO_LIMIT),
        .FIN_HOLD (FIN_HOLD)
    ) dut (
        .i_clk_usb         (clk),
        .i_rst_n           (rst_n),
        .i_cmd_come        (cmd_come),
        .i_cmd             (cmd),
        .i_cmd_param       (cmd_param),
        .o_cmd_finish      (cmd_finish),
        .o_cmd_finish_code (finish_code),
        .o_tgt_req         (tgt_req),
        .o_tgt_op          (tgt_op),
        .o_tgt_param       (tgt_param),
        .i_tgt_ack         (tgt_ack),
        .i_tgt_done        (tgt_done),
        .i_tgt_status      (tgt_status),
        .o_busy            (busy),
        .o_err_overrun     (err_overrun)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One host command. ack_dly: req-high cycle (1-based) on which the target acks;
    // done_dly: cycles from ack to done (0 = same cycle). Other lanes carry noise.
    task automatic applyStimulus(input logic [15:0] c, input logic [31:0] p,
                                 input int ack_dly, input int done_dly, input logic [7:0] st,
                                 input bit never_ack, input bit overrun);
        int idx, cyc, req_hi, ack_at, n_hi, n_gap, exp_req, exp_fin;
        bit valid, req_ok, fin;
        logic [N_TGT-1:0] lane;
        logic [15:0] exp_code;
        logic [7:0]  op_done;
        logic [31:0] par_done;
        idx = int'(c[15:8]);
        valid = (idx < N_TGT);
        lane = '0;
        if (valid) lane[idx] = 1'b1;
        cyc = 0; req_hi = 0; ack_at = -1; n_hi = 0; n_gap = 0;
        req_ok = 1'b1; fin = 1'b0; op_done = '0; par_done = '0;

        // Reference model: outcome follows from index validity and the handshake timing.
        if (!valid) begin
            exp_code = 16'h8001; exp_req = 0; exp_fin = 1;
        end else if (never_ack) begin
            exp_code = 16'h8002; exp_req = TO_LIMIT + 1; exp_fin = TO_LIMIT + 2;
        end else begin
            exp_code = {8'h00, st}; exp_req = ack_dly; exp_fin = ack_dly + done_dly + 1;
        end

        @(negedge clk);
        cmd = c; cmd_param = p; cmd_come = 1'b1;
        while (cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (cmd_finish) begin
                fin = 1'b1;
                break;
            end
            tgt_ack    = N_TGT'($urandom) & ~lane;
            tgt_done   = N_TGT'($urandom) & ~lane;
            tgt_status = $urandom;
            if (valid) tgt_status[8*idx +: 8] = st;
            if (tgt_req != '0) begin
                req_hi++;
                if (tgt_req !== lane) req_ok = 1'b0;
                if (!never_ack && req_hi == ack_dly) begin
                    tgt_ack[idx] = 1'b1;
                    ack_at = cyc;
                end else if (req_hi == 1 && ack_dly >= 2) begin
                    tgt_done[idx] = 1'b1;
                    tgt_status[8*idx +: 8] = ~st;
                end
            end
            if (ack_at >= 0 && cyc == ack_at + done_dly) begin
                tgt_done[idx] = 1'b1;
                op_done = tgt_op;
                par_done = tgt_param;
            end
            if (overrun && ack_at >= 0) begin
                if (cyc == ack_at + 1) cmd_come = 1'b0;
                if (cyc == ack_at + 2) begin
                    cmd_come = 1'b1;
                    cmd = ~c;
                end
            end
        end
        cmd_come = 1'b0; tgt_ack = '0; tgt_done = '0;
        if (overrun) exp_overrun = 1'b1;

        checkOutput("finish_seen", 64'(fin), 64'd1);
        checkOutput("finish_latency", 64'(cyc), 64'(exp_fin));
        checkOutput("req_cycles", 64'(req_hi), 64'(exp_req));
        checkOutput("req_lane", 64'(req_ok), 64'd1);
        checkOutput("finish_code", 64'(finish_code), 64'(exp_code));
        if (valid && !never_ack) begin
            checkOutput("op_at_done", 64'(op_done), 64'(c[7:0]));
            checkOutput("param_at_done", 64'(par_done), 64'(p));
        end
        while (cmd_finish && n_hi < 50) begin
            n_hi++;
            @(negedge clk);
        end
        while (busy && n_gap < 50) begin
            n_gap++;
            @(negedge clk);
        end
        checkOutput("finish_hold", 64'(n_hi), 64'(FIN_HOLD));
        checkOutput("gap_hold", 64'(n_gap), 64'(FIN_HOLD));
        checkOutput("code_stable", 64'(finish_code), 64'(exp_code));
        checkOutput("overrun_flag", 64'(err_overrun), 64'(exp_overrun));
    endtask

    initial begin
        int cyc, n_fin;
        bit fin;
        logic [N_TGT-1:0] req_at2;
        logic [7:0] r_idx;

        #12;
        checkOutput("rst_req", 64'(tgt_req), 64'd0);
        checkOutput("rst_finish", 64'(cmd_finish), 64'd0);
        checkOutput("rst_code", 64'(finish_code), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_overrun", 64'(err_overrun), 64'd0);
        checkOutput("rst_op", 64'(tgt_op), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(16'h0203, 32'h0000_1234, 3, 7, 8'h5A, 1'b0, 1'b0);
        applyStimulus(16'h0901, 32'h0000_0001, 1, 0, 8'h00, 1'b0, 1'b0);
        applyStimulus(16'h0105, 32'h0000_00AA, 0, 0, 8'h00, 1'b1, 1'b0);
        applyStimulus(16'h0011, 32'hDEAD_BEEF, 1, 0, 8'h01, 1'b0, 1'b0);
        applyStimulus(16'h0122, 32'h0BAD_F00D, 2, 5, 8'hC3, 1'b0, 1'b1);

        // Reset in the middle of a command drops req at once and yields no finish.
        @(negedge clk);
        cmd = 16'h0304; cmd_come = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("req_before_reset", 64'(tgt_req), 64'h8);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("req_async_reset", 64'(tgt_req), 64'd0);
        checkOutput("busy_async_reset", 64'(busy), 64'd0);
        checkOutput("overrun_cleared", 64'(err_overrun), 64'd0);
        cmd_come = 1'b0;
        exp_overrun = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_fin = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cmd_finish || busy) n_fin++;
        end
        checkOutput("no_finish_after_reset", 64'(n_fin), 64'd0);

`ifdef USB_CMD_BCAST_EN
        @(negedge clk);
        cmd = 16'hFF07; cmd_param = 32'h0000_CAFE; cmd_come = 1'b1;
        tgt_status = 32'h0804_0201;
        cyc = 0; fin = 1'b0; req_at2 = '0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            tgt_ack = '0; tgt_done = '0;
            if (cmd_finish) begin
                fin = 1'b1;
                break;
            end
            if (cyc == 2) req_at2 = tgt_req;
            for (int i = 0; i < N_TGT; i++) begin
                if (cyc == i + 1) tgt_ack[i] = 1'b1;
                if (cyc == 2*i + 3) tgt_done[i] = 1'b1;
            end
        end
        cmd_come = 1'b0;
        checkOutput("bcast_finish_seen", 64'(fin), 64'd1);
        checkOutput("bcast_latency", 64'(cyc), 64'd10);
        checkOutput("bcast_req_partial", 64'(req_at2), 64'hE);
        checkOutput("bcast_code", 64'(finish_code), 64'h000F);
        n_fin = 0;
        while (busy && n_fin < 50) begin
            n_fin++;
            @(negedge clk);
        end
`else
        applyStimulus(16'hFF07, 32'h0000_CAFE, 1, 0, 8'h00, 1'b0, 1'b0);
`endif

        for (int k = 0; k < 10; k++) begin
            r_idx = 8'($urandom_range(0, 5));
            applyStimulus({r_idx, 8'($urandom)}, $urandom, $urandom_range(1, 6),
                          $urandom_range(0, 8), 8'($urandom), 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
